// File: rtl/bitonic_sort_stream.sv
// bitonic_sort_stream
//   Fully pipelined N-lane bitonic sorter. It sorts one key vector per cycle.
//   Each key carries a payload and the index of the input lane it came from.
//   The direction (ascending or descending) is chosen per vector and travels
//   down the pipeline with that vector.
//
//   The pipeline has one register stage per compare-exchange layer, so
//   S = LOG_N*(LOG_N+1)/2 stages in total. Every stage advances together
//   whenever the output is empty or is being taken; otherwise every stage holds.
//
//   Lane packing: lane 0 occupies the most-significant field of each vector
//   bus, and lane N-1 the least-significant field.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     input handshake; in_ready is the global advance
//   in_desc                 0 = ascending, 1 = descending, for this vector
//   in_key, in_payload      N lanes of key and payload
//   out_valid / out_ready   output handshake
//   out_desc                direction the output vector was sorted with
//   out_key, out_payload    sorted lanes
//   out_idx                 original input lane of each output lane
module bitonic_sort_stream #(
  parameter int N         = 8,
  parameter int KEY_W     = 4,
  parameter int PAYLOAD_W = 8,
  parameter int LOG_N     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_desc,
  input  logic [N*KEY_W-1:0]     in_key,
  input  logic [N*PAYLOAD_W-1:0] in_payload,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_desc,
  output logic [N*KEY_W-1:0]     out_key,
  output logic [N*PAYLOAD_W-1:0] out_payload,
  output logic [N*LOG_N-1:0]     out_idx
);

  localparam int S  = LOG_N * (LOG_N + 1) / 2;
  localparam int CW = KEY_W + LOG_N;

  logic [S-1:0][N-1:0][KEY_W-1:0]     r_key, w_key_src, w_key_nx;
  logic [S-1:0][N-1:0][PAYLOAD_W-1:0] r_pay, w_pay_src, w_pay_nx;
  logic [S-1:0][N-1:0][LOG_N-1:0]     r_idx, w_idx_src, w_idx_nx;
  logic [S-1:0]                       r_valid, r_desc, w_valid_src, w_desc_src;
  logic                               w_adv;

  assign w_adv     = !r_valid[S-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[S-1];
  assign out_desc  = r_desc[S-1];

  // Layer inputs: layer 0 reads the ports, every later layer reads the
  // previous register. Data is zeroed when in_valid is low, so unknown input
  // values cannot reach the outputs.
  genvar gs, gi, gk, gj;
  for (gs = 0; gs < S; gs++) begin : g_src
    if (gs == 0) begin : g_in
      assign w_valid_src[0] = in_valid;
      assign w_desc_src[0]  = in_valid & in_desc;
      for (gi = 0; gi < N; gi++) begin : g_lane
        assign w_key_src[0][gi] = in_valid ? in_key[(N-1-gi)*KEY_W +: KEY_W] : '0;
        assign w_pay_src[0][gi] = in_valid ? in_payload[(N-1-gi)*PAYLOAD_W +: PAYLOAD_W] : '0;
        assign w_idx_src[0][gi] = LOG_N'(gi);
      end
    end else begin : g_reg
      assign w_valid_src[gs] = r_valid[gs-1];
      assign w_desc_src[gs]  = r_desc[gs-1];
      assign w_key_src[gs]   = r_key[gs-1];
      assign w_pay_src[gs]   = r_pay[gs-1];
      assign w_idx_src[gs]   = r_idx[gs-1];
    end
  end

  // Compare-exchange layers. Merge phase gk uses blocks of 2^gk lanes.
  // Sub-step gj compares lanes that are 2^(gj-1) apart. A vector sorted
  // descending flips the direction of every block.
  // The tie field (lane index, inverted when descending) makes every composite
  // key unique. Equal keys therefore always leave in ascending lane order.
  for (gk = 1; gk <= LOG_N; gk++) begin : g_phase
    for (gj = gk; gj >= 1; gj--) begin : g_step
      localparam int ST  = (gk - 1) * gk / 2 + (gk - gj);
      localparam int D   = 1 << (gj - 1);
      localparam int BLK = 1 << gk;
      for (gi = 0; gi < N; gi++) begin : g_pair
        if ((gi & D) == 0) begin : g_ce
          localparam int L  = gi + D;
          localparam bit UP = ((gi & BLK) == 0);
          logic          w_swap;
          logic [CW-1:0] w_ci, w_cl;

          assign w_ci   = {w_key_src[ST][gi], w_idx_src[ST][gi] ^ {LOG_N{w_desc_src[ST]}}};
          assign w_cl   = {w_key_src[ST][L],  w_idx_src[ST][L]  ^ {LOG_N{w_desc_src[ST]}}};
          assign w_swap = (UP ^ w_desc_src[ST]) ? (w_ci > w_cl) : (w_ci < w_cl);

          assign w_key_nx[ST][gi] = w_swap ? w_key_src[ST][L]  : w_key_src[ST][gi];
          assign w_key_nx[ST][L]  = w_swap ? w_key_src[ST][gi] : w_key_src[ST][L];
          assign w_pay_nx[ST][gi] = w_swap ? w_pay_src[ST][L]  : w_pay_src[ST][gi];
          assign w_pay_nx[ST][L]  = w_swap ? w_pay_src[ST][gi] : w_pay_src[ST][L];
          assign w_idx_nx[ST][gi] = w_swap ? w_idx_src[ST][L]  : w_idx_src[ST][gi];
          assign w_idx_nx[ST][L]  = w_swap ? w_idx_src[ST][gi] : w_idx_src[ST][L];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_desc  <= '0;
      r_key   <= '0;
      r_pay   <= '0;
      r_idx   <= '0;
    end else if (w_adv) begin
      r_valid <= w_valid_src;
      r_desc  <= w_desc_src;
      r_key   <= w_key_nx;
      r_pay   <= w_pay_nx;
      r_idx   <= w_idx_nx;
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_out
    assign out_key[(N-1-gi)*KEY_W +: KEY_W]             = r_key[S-1][gi];
    assign out_payload[(N-1-gi)*PAYLOAD_W +: PAYLOAD_W] = r_pay[S-1][gi];
    assign out_idx[(N-1-gi)*LOG_N +: LOG_N]             = r_idx[S-1][gi];
  end

endmodule

// File: tb/tb_bitonic_sort_stream.sv
// Testbench for bitonic_sort_stream with N=8, KEY_W=4, PAYLOAD_W=8.
// It runs directed vectors, a back-to-back run with a stall, a flush by reset,
// and randomized traffic. The randomized traffic is checked against a stable
// selection-sort model.
module tb_bitonic_sort_stream;

  localparam int N  = 8;
  localparam int KW = 4;
  localparam int PW = 8;
  localparam int LG = 3;
  localparam int S  = 6;

  typedef struct packed {
    logic [N*KW-1:0] k;
    logic [N*PW-1:0] p;
    logic [N*LG-1:0] i;
    logic            d;
  } exp_t;

  logic            clk = 0;
  logic            reset;
  logic            in_valid, in_ready, in_desc;
  logic [N*KW-1:0] in_key;
  logic [N*PW-1:0] in_payload;
  logic            out_valid, out_ready, out_desc;
  logic [N*KW-1:0] out_key;
  logic [N*PW-1:0] out_payload;
  logic [N*LG-1:0] out_idx;

  int total = 0;
  int bad   = 0;

  bitonic_sort_stream #(.N(N), .KEY_W(KW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
    .in_key(in_key), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_desc(out_desc),
    .out_key(out_key), .out_payload(out_payload), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  // Stable sort by repeated selection: take the best remaining key each time.
  // On a tie the lowest lane wins.
  function automatic exp_t model(input logic [N*KW-1:0] k, input logic [N*PW-1:0] p,
                                 input logic d);
    exp_t          e;
    bit            used [N];
    int            best;
    logic [KW-1:0] kl, kb;
    e   = '0;
    e.d = d;
    for (int l = 0; l < N; l++) used[l] = 0;
    for (int pos = 0; pos < N; pos++) begin
      best = -1;
      for (int l = 0; l < N; l++) begin
        if (!used[l]) begin
          if (best < 0) best = l;
          else begin
            kl = k[(N-1-l)*KW +: KW];
            kb = k[(N-1-best)*KW +: KW];
            if (d ? (kl > kb) : (kl < kb)) best = l;
          end
        end
      end
      used[best] = 1;
      e.k[(N-1-pos)*KW +: KW] = k[(N-1-best)*KW +: KW];
      e.p[(N-1-pos)*PW +: PW] = p[(N-1-best)*PW +: PW];
      e.i[(N-1-pos)*LG +: LG] = LG'(best);
    end
    return e;
  endfunction

  function automatic exp_t snap();
    return exp_t'({out_key, out_payload, out_idx, out_desc});
  endfunction

  // Sends one vector into an idle pipeline. Returns the number of clock edges
  // from acceptance until out_valid is seen (-1 on timeout), plus the outputs.
  task automatic run_one(input logic [N*KW-1:0] k, input logic [N*PW-1:0] p, input logic d,
                         output int lat, output exp_t got);
    out_ready  = 1;
    in_valid   = 1;
    in_key     = k;
    in_payload = p;
    in_desc    = d;
    lat        = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      in_valid   = 0;
      in_key     = $urandom;
      in_payload = {$urandom, $urandom};
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    got = snap();
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (snap() !== exp_t'(0)) begin bad++; $display("FAIL rst_outputs got=%h exp=0", snap()); end
  endtask

  task automatic test_directed(input logic d, input logic [N*KW-1:0] ek, input int il [N]);
    int                lat;
    exp_t              got;
    logic [N*PW-1:0]   p, ep;
    logic [N*LG-1:0]   ei;
    p = {$urandom, $urandom};
    for (int l = 0; l < N; l++) begin
      ei[(N-1-l)*LG +: LG] = LG'(il[l]);
      ep[(N-1-l)*PW +: PW] = p[(N-1-il[l])*PW +: PW];
    end
    run_one(32'h0923_58f4, p, d, lat, got);
    total++; if (lat !== S) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", d, lat, S); end
    total++; if (got.k !== ek) begin bad++; $display("FAIL dir%0d_key got=%h exp=%h", d, got.k, ek); end
    total++; if (got.i !== ei) begin bad++; $display("FAIL dir%0d_idx got=%h exp=%h", d, got.i, ei); end
    total++; if (got.p !== ep) begin bad++; $display("FAIL dir%0d_payload got=%h exp=%h", d, got.p, ep); end
    total++; if (got.d !== d) begin bad++; $display("FAIL dir%0d_desc got=%b exp=%b", d, got.d, d); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_dup got=%b exp=0", d, out_valid); end
  endtask

  task automatic test_ties();
    exp_t            g0, g1;
    logic [N*LG-1:0] eid;
    logic            v1;
    int              seen;
    for (int l = 0; l < N; l++) eid[(N-1-l)*LG +: LG] = LG'(l);
    out_ready  = 1;
    in_valid   = 1;
    in_key     = 32'h7777_7777;
    in_payload = {$urandom, $urandom};
    in_desc    = 0;
    @(posedge clk); #1;
    in_desc    = 1;
    @(posedge clk); #1;
    in_valid   = 0;
    seen = 0;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    seen = out_valid;
    g0 = snap();
    @(posedge clk); #1;
    v1 = out_valid;
    g1 = snap();
    total++; if (seen !== 1) begin bad++; $display("FAIL ties_timeout got=%0d exp=1", seen); end
    total++; if (g0.i !== eid || g0.d !== 1'b0) begin bad++; $display("FAIL ties_asc got=%h/%b exp=%h/0", g0.i, g0.d, eid); end
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL ties_second_valid got=%b exp=1", v1); end
    total++; if (g1.i !== eid || g1.d !== 1'b1) begin bad++; $display("FAIL ties_desc got=%h/%b exp=%h/1", g1.i, g1.d, eid); end
    total++; if (g1.k !== 32'h7777_7777) begin bad++; $display("FAIL ties_key got=%h exp=77777777", g1.k); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [N*KW-1:0] vk [10];
    logic [N*PW-1:0] vp [10];
    logic            vd [10];
    exp_t            ex [10];
    int              oc [10];
    int              nin, nout, stall;
    for (int v = 0; v < 10; v++) begin
      vk[v] = $urandom;
      vp[v] = {$urandom, $urandom};
      vd[v] = 1'($urandom % 2);
      ex[v] = model(vk[v], vp[v], vd[v]);
      oc[v] = 0;
    end
    nin = 0; nout = 0; stall = 0;
    for (int c = 0; c < 80 && nout < 10; c++) begin
      if (nin < 10) begin
        in_valid = 1; in_key = vk[nin]; in_payload = vp[nin]; in_desc = vd[nin];
      end else in_valid = 0;
      out_ready = !(out_valid && nout == 8 && stall < 3);
      #1;
      if (!out_ready) begin
        stall++;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready got=%b exp=0", in_ready); end
        total++; if (snap() !== ex[8]) begin bad++; $display("FAIL b2b_frozen got=%h exp=%h", snap(), ex[8]); end
      end else if (out_valid) begin
        total++; if (snap() !== ex[nout]) begin bad++; $display("FAIL b2b_vec%0d got=%h exp=%h", nout, snap(), ex[nout]); end
        oc[nout] = c;
        nout++;
      end
      if (in_valid && in_ready) nin++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    total++; if (nout !== 10) begin bad++; $display("FAIL b2b_count got=%0d exp=10", nout); end
    total++; if (oc[7] - oc[0] !== 7) begin bad++; $display("FAIL b2b_consecutive got=%0d exp=7", oc[7] - oc[0]); end
    total++; if (oc[8] - oc[7] !== 4 || oc[9] - oc[8] !== 1) begin
      bad++; $display("FAIL b2b_stall_timing got=%0d,%0d exp=4,1", oc[8] - oc[7], oc[9] - oc[8]);
    end
  endtask

  task automatic test_reset_flush();
    int   lat, seen;
    exp_t got, e;
    logic [N*KW-1:0] k;
    logic [N*PW-1:0] p;
    out_ready = 1;
    for (int v = 0; v < 4; v++) begin
      in_valid = 1; in_key = $urandom; in_payload = {$urandom, $urandom}; in_desc = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    in_valid = 0;
    reset    = 1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_after_reset got=%b/%b exp=0/1", out_valid, in_ready);
    end
    reset = 0;
    seen  = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_leak got=%0d exp=0", seen); end
    k = $urandom; p = {$urandom, $urandom};
    e = model(k, p, 1'b0);
    run_one(k, p, 1'b0, lat, got);
    total++; if (lat !== S) begin bad++; $display("FAIL flush_post_latency got=%0d exp=%0d", lat, S); end
    total++; if (got !== e) begin bad++; $display("FAIL flush_post_vec got=%h exp=%h", got, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int cycles);
    exp_t            q [$];
    exp_t            e, prev;
    logic            prev_hold;
    logic [N*KW-1:0] kk;
    prev_hold = 0;
    prev      = '0;
    for (int c = 0; c < cycles + 40; c++) begin
      if (c < cycles) begin
        in_valid  = ($urandom % 4) != 0;
        out_ready = ($urandom % 4) != 0;
        in_desc   = 1'($urandom % 2);
        if ($urandom % 2) begin
          for (int l = 0; l < N; l++) kk[(N-1-l)*KW +: KW] = KW'($urandom_range(0, 2));
        end else kk = $urandom;
        in_key     = kk;
        in_payload = {$urandom, $urandom};
      end else begin
        in_valid  = 0;
        out_ready = 1;
      end
      #1;
      if (prev_hold) begin
        total++; if (out_valid !== 1'b1 || snap() !== prev) begin
          bad++; $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", c, out_valid, snap(), prev);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected cyc=%0d got=%h exp=none", c, snap());
        end else begin
          e = q.pop_front();
          if (snap() !== e) begin bad++; $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", c, snap(), e); end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev      = snap();
      if (in_valid && in_ready) q.push_back(model(in_key, in_payload, in_desc));
      @(posedge clk); #1;
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rnd_lost got=%0d exp=0", q.size()); end
  endtask

  initial begin
    int il_asc [N];
    int il_desc [N];
    il_asc  = '{0, 2, 3, 7, 4, 5, 1, 6};
    il_desc = '{6, 1, 5, 4, 7, 3, 2, 0};
    reset = 1; in_valid = 0; out_ready = 0; in_desc = 0; in_key = '0; in_payload = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    test_reset();
    test_directed(1'b0, 32'h0234_589f, il_asc);
    test_directed(1'b1, 32'hf985_4320, il_desc);
    test_ties();
    test_back_to_back();
    test_reset_flush();
    test_random(4000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
